// File: rtl/iir_pkg.sv
// iir_pkg: shared types, coefficient slots and width helpers for the biquad sequencer
package iir_pkg;
    typedef enum logic [3:0] {IDLE, S0, S1, S2, RW, S3, S4, S5, OUT} state_t;
    localparam int SLOT_G = 0;
    localparam int SLOT_A1 = 1;
    localparam int SLOT_A2 = 2;
    localparam int SLOT_B0 = 3;
    localparam int SLOT_B1 = 4;
    localparam int SLOT_B2 = 5;
    localparam int NSLOT = 6;
    function automatic int acc_w(input int w);
        return 2 * w + 2;
    endfunction
    function automatic longint coef_one(input int frac);
        return longint'(1) <<< frac;
    endfunction
endpackage

// File: rtl/iir_biquad_seq_if.sv
// iir_biquad_seq_if: sample, result, coefficient and control signals of the biquad sequencer
interface iir_biquad_seq_if #(
    parameter int W = 25,
    parameter int CHW = 1
);
    logic in_valid;
    logic in_ready;
    logic [CHW-1:0] in_ch;
    logic signed [W-1:0] in_data;
    logic out_valid;
    logic [CHW-1:0] out_ch;
    logic signed [W-1:0] out_data;
    logic out_sat;
    logic coef_we;
    logic [2:0] coef_addr;
    logic signed [W-1:0] coef_data;
    logic clear_state;
    logic busy;
    modport master (
        output in_valid, in_ch, in_data, coef_we, coef_addr, coef_data, clear_state,
        input in_ready, out_valid, out_ch, out_data, out_sat, busy
    );
    modport slave (
        input in_valid, in_ch, in_data, coef_we, coef_addr, coef_data, clear_state,
        output in_ready, out_valid, out_ch, out_data, out_sat, busy
    );
endinterface

// File: rtl/iir_round_sat.sv
// iir_round_sat: round-half-up rescale of the accumulator, clamp to W bits, flag clamping
module iir_round_sat #(
    parameter int W = 25,
    parameter int FRAC = 16,
    parameter int AW = 52
) (
    input logic signed [AW-1:0] acc,
    output logic signed [W-1:0] y,
    output logic sat
);
    localparam logic signed [AW-1:0] RND = AW'(1) <<< (FRAC - 1);
    localparam logic signed [AW-1:0] MAXV = {{(AW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = ~MAXV;
    logic signed [AW-1:0] r;
    assign r = (acc + RND) >>> FRAC;
    assign sat = r > MAXV || r < MINV;
    assign y = r > MAXV ? MAXV[W-1:0] : r < MINV ? MINV[W-1:0] : r[W-1:0];
endmodule

// File: rtl/iir_biquad_seq.sv
// iir_biquad_seq: self-sequenced direct-form-II biquad sharing one MAC across NCH channels
module iir_biquad_seq
    import iir_pkg::*;
#(
    parameter int W = 25,
    parameter int FRAC = 16,
    parameter int NCH = 2
) (
    input logic clk,
    input logic rst,
    iir_biquad_seq_if.slave bus
);
    localparam int CHW = $clog2(NCH);
    localparam int AW = acc_w(W);
    localparam logic signed [W-1:0] ONE = W'(coef_one(FRAC));
    state_t state, nxt;
    logic signed [W-1:0] coef [NSLOT];
    logic signed [W-1:0] w1 [NCH];
    logic signed [W-1:0] w2 [NCH];
    logic signed [W-1:0] x_r, w_tmp, w_rs, y_rs, mc, md;
    logic [CHW-1:0] ch_r;
    logic signed [AW-1:0] acc;
    logic signed [2*W-1:0] prod;
    logic sat_r, w_sat, y_sat, accept, idle;

    assign idle = state == IDLE;
    assign bus.in_ready = idle && !bus.clear_state && !rst;
    assign bus.busy = !idle;
    assign accept = bus.in_valid && bus.in_ready;
    assign prod = mc * md;

    iir_round_sat #(.W(W), .FRAC(FRAC), .AW(AW)) u_rs_w (.acc(acc), .y(w_rs), .sat(w_sat));
    iir_round_sat #(.W(W), .FRAC(FRAC), .AW(AW)) u_rs_y (.acc(acc), .y(y_rs), .sat(y_sat));

    // State register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= nxt;

    // Next state: wait for a sample, then walk the fixed MAC schedule once
    always_comb
        nxt = idle ? (accept ? S0 : IDLE) : state == OUT ? IDLE : state_t'(state + 4'd1);

    // MAC operand select for each schedule step
    always_comb begin
        mc = '0;
        md = '0;
        case (state)
            S0: begin mc = coef[SLOT_G]; md = x_r; end
            S1: begin mc = coef[SLOT_A1]; md = w1[ch_r]; end
            S2: begin mc = coef[SLOT_A2]; md = w2[ch_r]; end
            S3: begin mc = coef[SLOT_B0]; md = w_tmp; end
            S4: begin mc = coef[SLOT_B1]; md = w1[ch_r]; end
            S5: begin mc = coef[SLOT_B2]; md = w2[ch_r]; end
            default: ;
        endcase
    end

    // Sample capture, accumulation and the intermediate w register
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            x_r <= '0;
            ch_r <= '0;
            acc <= '0;
            w_tmp <= '0;
            sat_r <= 1'b0;
        end else if (accept) begin
            x_r <= bus.in_data;
            ch_r <= bus.in_ch;
            acc <= '0;
            sat_r <= 1'b0;
        end else if (state == RW) begin
            w_tmp <= w_rs;
            sat_r <= w_sat;
            acc <= '0;
        end else if (!idle && state != OUT) acc <= acc + AW'(prod);

    // Coefficients change only between samples so a sample never sees a mixed set
    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < NSLOT; i++) coef[i] <= (i == SLOT_G || i == SLOT_B0) ? ONE : '0;
        else if (idle && bus.coef_we && bus.coef_addr < 3'(NSLOT)) coef[bus.coef_addr] <= bus.coef_data;

    // Per-channel delay line: bulk clear in idle, shift on result
    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < NCH; i++) begin
            w1[i] <= '0;
            w2[i] <= '0;
        end else if (idle && bus.clear_state) for (int i = 0; i < NCH; i++) begin
            w1[i] <= '0;
            w2[i] <= '0;
        end else if (state == OUT) begin
            w2[ch_r] <= w1[ch_r];
            w1[ch_r] <= w_tmp;
        end

    // Result registers hold until the next result
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_ch <= '0;
            bus.out_sat <= 1'b0;
        end else begin
            bus.out_valid <= state == OUT;
            if (state == OUT) begin
                bus.out_data <= y_rs;
                bus.out_ch <= ch_r;
                bus.out_sat <= sat_r | y_sat;
            end
        end
endmodule
